// File: rtl/sync_gray_ptr_n.sv
// Synchronises a Gray write pointer into r_clk, adds Gray->binary, change strobe/delta, Gray-violation flag and fill qualifier.
// Latency: STAGES edges to rsync_gray, STAGES+1 edges to rsync_bin/ptr_upd/ptr_delta/gray_err.
// Backpressure: none; outputs valid every cycle once sync_rdy is high.
module sync_gray_ptr_n #(
  parameter int DEPTH     = 8,
  parameter int STAGES    = 2,
  parameter int ERR_CHECK = 1
) (
  input  logic                   r_clk,
  input  logic                   rst_n,
  input  logic [$clog2(DEPTH):0] wptr_gray,
  input  logic                   err_clr,
  output logic [$clog2(DEPTH):0] rsync_gray,
  output logic [$clog2(DEPTH):0] rsync_bin,
  output logic                   ptr_upd,
  output logic [$clog2(DEPTH):0] ptr_delta,
  output logic                   gray_err,
  output logic                   sync_rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [2:0] FILL_LAST = 3'(STAGES);
  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

  // Illegal configurations stop elaboration rather than silently misbehaving.
  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("sync_gray_ptr_n: STAGES must be in 2..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_gray_ptr_n: DEPTH must be a power of 2");
    end
  endgenerate

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] sync_q [STAGES];
  logic [PW-1:0] g_q;
  logic [PW-1:0] bin_q,   bin_d;
  logic [PW-1:0] delta_q, delta_d;
  logic          upd_q,   upd_d;
  logic          err_q,   err_d;
  logic          rdy_q,   rdy_d;
  logic [2:0]    fill_q,  fill_d;

  logic [PW-1:0] gray_diff;
  logic          upd_raw;
  logic          multi_bit;
  logic          err_raw;

  // Metastability chain: first flop samples the asynchronous pointer, the rest only settle it.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_gray;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign rsync_gray = sync_q[STAGES-1];

  // Post-chain stage: compare against the previous synchronised value and derive qualifiers.
  always_comb begin
    gray_diff = rsync_gray ^ g_q;
    upd_raw   = (rsync_gray != g_q);
    // More than one bit set <=> clearing the lowest set bit leaves something behind.
    multi_bit = |(gray_diff & (gray_diff - ONE));
    err_raw   = (ERR_CHECK != 0) && rdy_q && multi_bit;

    bin_d   = g2b(rsync_gray);
    upd_d   = rdy_q & upd_raw;
    delta_d = '0;
    if (rdy_q && upd_raw) begin
      // Modular difference, so a wrap through zero still reports the true step count.
      delta_d = g2b(rsync_gray) - g2b(g_q);
    end
    // A fresh violation outranks a clear arriving on the same edge.
    err_d = err_raw | (err_q & ~err_clr);
  end

  // Registers for the post-chain stage.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      g_q     <= rsync_gray;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  // Fill counter: saturates once the chain and compare stage hold post-reset data.
  always_comb begin
    fill_d = (fill_q == FILL_LAST) ? fill_q : fill_q + 3'd1;
    rdy_d  = rdy_q | (fill_q == FILL_LAST);
  end

  // Fill counter and ready flag registers; ready is sticky until the next reset.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      rdy_q  <= rdy_d;
    end
  end

  assign rsync_bin = bin_q;
  assign ptr_upd   = upd_q;
  assign ptr_delta = delta_q;
  assign gray_err  = err_q;
  assign sync_rdy  = rdy_q;

endmodule

// File: tb/tb_sync_gray_ptr_n.sv
// Bench for sync_gray_ptr_n: a STAGES=2 and a STAGES=3 instance share clock, reset and inputs.
// Every edge both are compared against a history-based reference model.
// Directed tables and sequences cover latency, wrap, violations, reset-release and mid-run reset.
module tb_sync_gray_ptr_n;

  localparam int PW = 4;

  logic          r_clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] wptr_gray;
  logic          err_clr;

  logic [PW-1:0] rs2, bin2, dl2;
  logic          upd2, err2, rdy2;
  logic [PW-1:0] rs3, bin3, dl3;
  logic          upd3, err3, rdy3;

  int checks = 0;
  int errors = 0;

  always #5 r_clk = ~r_clk;

  sync_gray_ptr_n #(.DEPTH(8), .STAGES(2), .ERR_CHECK(1)) u_dut2 (
    .r_clk(r_clk), .rst_n(rst_n), .wptr_gray(wptr_gray), .err_clr(err_clr),
    .rsync_gray(rs2), .rsync_bin(bin2), .ptr_upd(upd2), .ptr_delta(dl2),
    .gray_err(err2), .sync_rdy(rdy2)
  );

  sync_gray_ptr_n #(.DEPTH(8), .STAGES(3), .ERR_CHECK(1)) u_dut3 (
    .r_clk(r_clk), .rst_n(rst_n), .wptr_gray(wptr_gray), .err_clr(err_clr),
    .rsync_gray(rs3), .rsync_bin(bin3), .ptr_upd(upd3), .ptr_delta(dl3),
    .gray_err(err3), .sync_rdy(rdy3)
  );

  // ---------------- reference model ----------------
  // in_q[j] is the input value sampled at the (j+1)th edge after reset release.
  logic [PW-1:0] in_q[$];
  int            n = 0;
  logic          m_err2 = 1'b0;
  logic          m_err3 = 1'b0;

  // Synchronised Gray value visible after edge m: the sample taken s-1 edges earlier.
  function automatic logic [PW-1:0] m_rs(input int s, input int m);
    int j;
    if (m < 1) return '0;
    j = m - s;
    if (j < 0) return '0;
    return in_q[j];
  endfunction

  function automatic logic [PW-1:0] m_g2b(input logic [PW-1:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [PW-1:0] m_b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic m_rdy(input int s, input int m);
    return (m >= s + 1);
  endfunction

  function automatic logic m_upd(input int s, input int m);
    return m_rdy(s, m - 1) && (m_rs(s, m - 1) != m_rs(s, m - 2));
  endfunction

  function automatic logic [PW-1:0] m_delta(input int s, input int m);
    logic [PW-1:0] d;
    d = '0;
    if (m_upd(s, m)) d = m_g2b(m_rs(s, m - 1)) - m_g2b(m_rs(s, m - 2));
    return d;
  endfunction

  function automatic logic m_raw(input int s, input int m);
    return m_rdy(s, m - 1) && ($countones(m_rs(s, m - 1) ^ m_rs(s, m - 2)) > 1);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("s2 rsync_gray", rs2,  m_rs(2, n));
    chk("s2 rsync_bin",  bin2, m_g2b(m_rs(2, n - 1)));
    chk("s2 ptr_upd",    upd2, m_upd(2, n));
    chk("s2 ptr_delta",  dl2,  m_delta(2, n));
    chk("s2 gray_err",   err2, m_err2);
    chk("s2 sync_rdy",   rdy2, m_rdy(2, n));
    chk("s3 rsync_gray", rs3,  m_rs(3, n));
    chk("s3 rsync_bin",  bin3, m_g2b(m_rs(3, n - 1)));
    chk("s3 ptr_upd",    upd3, m_upd(3, n));
    chk("s3 ptr_delta",  dl3,  m_delta(3, n));
    chk("s3 gray_err",   err3, m_err3);
    chk("s3 sync_rdy",   rdy3, m_rdy(3, n));
  endtask

  // Drive inputs, take one edge, advance the model, compare 1 time unit after the edge.
  task automatic step(input logic [PW-1:0] w, input logic clr);
    wptr_gray = w;
    err_clr   = clr;
    @(posedge r_clk);
    if (rst_n) begin
      in_q.push_back(wptr_gray);
      n++;
      m_err2 = m_raw(2, n) | (m_err2 & ~err_clr);
      m_err3 = m_raw(3, n) | (m_err3 & ~err_clr);
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset between edges; outputs must already be clear before any edge.
  task automatic do_reset(input logic [PW-1:0] w);
    wptr_gray = w;
    err_clr   = 1'b0;
    #2;
    rst_n = 1'b0;
    n = 0;
    in_q.delete();
    m_err2 = 1'b0;
    m_err3 = 1'b0;
    #1;
    check_all();
    @(negedge r_clk);
    @(negedge r_clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table (STAGES=2 instance) ----------------
  typedef struct {
    logic [PW-1:0] w;
    logic          clr;
    logic [PW-1:0] rs;
    logic [PW-1:0] bin;
    logic          upd;
    logic [PW-1:0] dl;
    logic          err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int lat2, lat3, pulses, bad;
    logic [PW-1:0] cur;

    // 1-bit step 0000->0001, then a 2-bit violation, clear, and clear colliding with a new violation.
    tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{4'b0001, 1'b0, 4'b0001, 4'd1, 1'b1, 4'd1, 1'b0};
    tbl[3]  = '{4'b0001, 1'b0, 4'b0001, 4'd1, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{4'b0010, 1'b0, 4'b0001, 4'd1, 1'b0, 4'd0, 1'b0};
    tbl[5]  = '{4'b0010, 1'b0, 4'b0010, 4'd1, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{4'b0010, 1'b0, 4'b0010, 4'd3, 1'b1, 4'd2, 1'b1};
    tbl[7]  = '{4'b0010, 1'b1, 4'b0010, 4'd3, 1'b0, 4'd0, 1'b0};
    tbl[8]  = '{4'b0010, 1'b0, 4'b0010, 4'd3, 1'b0, 4'd0, 1'b0};
    tbl[9]  = '{4'b0111, 1'b0, 4'b0010, 4'd3, 1'b0, 4'd0, 1'b0};
    tbl[10] = '{4'b0111, 1'b0, 4'b0111, 4'd3, 1'b0, 4'd0, 1'b0};
    tbl[11] = '{4'b0111, 1'b1, 4'b0111, 4'd5, 1'b1, 4'd2, 1'b1};
    tbl[12] = '{4'b0111, 1'b0, 4'b0111, 4'd5, 1'b0, 4'd0, 1'b1};
    tbl[13] = '{4'b0111, 1'b1, 4'b0111, 4'd5, 1'b0, 4'd0, 1'b0};

    rst_n     = 1'b0;
    wptr_gray = '0;
    err_clr   = 1'b0;
    @(posedge r_clk);
    @(posedge r_clk);
    #1;

    // Reset state and fill timing with the input held at zero.
    do_reset(4'b0000);
    for (int e = 1; e <= 5; e++) begin
      step(4'b0000, 1'b0);
      chk("fill rdy2", rdy2, (e >= 3));
      chk("fill rdy3", rdy3, (e >= 4));
    end

    // Table-driven sequence on the STAGES=2 instance.
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].w, tbl[i].clr);
      chk($sformatf("tbl%0d rsync_gray", i), rs2,  tbl[i].rs);
      chk($sformatf("tbl%0d rsync_bin", i),  bin2, tbl[i].bin);
      chk($sformatf("tbl%0d ptr_upd", i),    upd2, tbl[i].upd);
      chk($sformatf("tbl%0d ptr_delta", i),  dl2,  tbl[i].dl);
      chk($sformatf("tbl%0d gray_err", i),   err2, tbl[i].err);
    end

    // Latency from input change to ptr_upd: STAGES+1 edges.
    do_reset(4'b0000);
    for (int e = 0; e < 6; e++) step(4'b0000, 1'b0);
    lat2 = -1;
    lat3 = -1;
    for (int e = 1; e <= 10; e++) begin
      step(4'b0001, 1'b0);
      if (upd2 && lat2 < 0) lat2 = e;
      if (upd3 && lat3 < 0) lat3 = e;
    end
    chk("latency s2", lat2, 3);
    chk("latency s3", lat3, 4);

    // Reset asserted mid-walk, then refill.
    step(4'b0011, 1'b0);
    step(4'b0010, 1'b0);
    do_reset(4'b0000);
    chk("midrst upd3", upd3, 0);
    chk("midrst rdy3", rdy3, 0);
    for (int e = 1; e <= 5; e++) begin
      step(4'b0000, 1'b0);
      chk("refill rdy3", rdy3, (e >= 4));
    end

    // Full Gray walk including the wrap back to zero.
    pulses = 0;
    bad    = 0;
    for (int b = 1; b <= 20; b++) begin
      cur = (b <= 16) ? m_b2g(4'(b)) : 4'b0000;
      step(cur, 1'b0);
      if (upd2) begin
        pulses++;
        if (dl2 != 4'd1) bad++;
      end
    end
    chk("walk pulses", pulses, 16);
    chk("walk bad deltas", bad, 0);
    chk("walk final bin", bin2, 0);
    chk("walk gray_err", err2, 0);

    // Non-zero pointer across reset release: no qualifiers until ready.
    do_reset(4'b0110);
    for (int e = 1; e <= 6; e++) begin
      step(4'b0110, 1'b0);
      chk("rel0110 upd2", upd2, 0);
      chk("rel0110 err2", err2, 0);
      chk("rel0110 upd3", upd3, 0);
    end
    chk("rel0110 bin2", bin2, 4);
    chk("rel0110 bin3", bin3, 4);

    // Randomised traffic: mostly holds and single steps, some jumps, clears and resets.
    cur = 4'd4;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(199);
      if (r == 0) begin
        do_reset(m_b2g(cur));
      end else if (r < 60) begin
        cur = cur + 4'd1;
      end else if (r < 75) begin
        cur = 4'($urandom_range(15));
      end
      step(m_b2g(cur), ($urandom_range(9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
